// File: rtl/fetch_queue.sv
// Instruction fetch stage: prefetches words from an in-order, variable-latency imem
// into a DEPTH-entry queue and hands {instr, pc, pc+4} to decode; redirects flush it.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] occ, outst, drop;
  logic [AW-1:0] head, tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   pc_fifo [MAX_OUTST];
  logic [PW-1:0] pf_rd, pf_wr;

  logic          fire, resp, push, pop;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count queued entries plus live (non-dropped) requests in flight.
  always_comb begin
    credit_used   = {1'b0, occ} + {1'b0, outst} - {1'b0, drop};
    imem_req_o    = !rst_i && !redirect_i && (outst < CW'(MAX_OUTST))
                    && (credit_used < (CW + 1)'(DEPTH));
    imem_addr_o   = fetch_pc;
    fire          = imem_req_o && imem_gnt_i;
    resp          = imem_rvalid_i && (outst != '0);
    push          = resp && (drop == '0) && !redirect_i;
    id_valid_o    = (occ != '0) && !redirect_i;
    pop           = id_valid_o && id_ready_i;
    id_instr_o    = '0;
    id_pc_o       = '0;
    id_pc_plus4_o = '0;
    if (id_valid_o) begin
      id_instr_o    = q_instr[head];
      id_pc_o       = q_pc[head];
      id_pc_plus4_o = q_pc[head] + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      occ      <= '0;
      outst    <= '0;
      drop     <= '0;
      head     <= '0;
      tail     <= '0;
      pf_rd    <= '0;
      pf_wr    <= '0;
    end else begin
      outst <= outst + CW'(fire) - CW'(resp);
      if (fire) pf_wr <= pf_inc(pf_wr);
      if (resp) pf_rd <= pf_inc(pf_rd);
      if (redirect_i) begin
        // The response landing this cycle is already gone, so it is excluded from drop.
        fetch_pc <= redirect_pc_i & ~32'h3;
        occ      <= '0;
        head     <= '0;
        tail     <= '0;
        drop     <= outst - CW'(resp) + CW'(fire);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop != '0)) drop <= drop - CW'(1);
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire) pc_fifo[pf_wr] <= fetch_pc;
    if (push) begin
      q_instr[tail] <= imem_rdata_i;
      q_pc[tail]    <= pc_fifo[pf_rd];
    end
  end

  a_rvalid_outst: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && (outst == '0)));
  a_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (occ == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: an in-order memory model with random latency, and a
// scoreboard of the expected instruction stream (fed at grant, checked at decode pop).
module tb_fetch_queue;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int unsigned epoch; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int unsigned n_cmp = 0, n_fail = 0;
  int unsigned epoch = 0, resp_epoch = 0, inflight = 0, model_occ = 0, pop_count = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  int          cyc = 0;
  logic [31:0] model_addr = RESET_PC;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: predicts handshakes from the model, then updates the model with this cycle's events.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
        exp_q.delete();
        model_addr = RESET_PC;
        model_occ  = 0;
        inflight   = 0;
        epoch++;
      end else begin
        if (!id_valid_o) begin
          check("idle_instr", id_instr_o, 32'd0);
          check("idle_pc", id_pc_o, 32'd0);
          check("idle_pc4", id_pc_plus4_o, 32'd0);
        end
        check("id_valid", {31'b0, id_valid_o}, {31'b0, (model_occ != 0) && !redirect_i});
        check("req", {31'b0, imem_req_o},
              {31'b0, !redirect_i && (inflight < MAX_OUTST) && (exp_q.size() < DEPTH)});
        if (imem_req_o) check("req_addr", imem_addr_o, model_addr);
        if (imem_rvalid_i) begin
          if (inflight == 0) fail_now("spurious_rvalid");
          else begin
            inflight--;
            if (!redirect_i && resp_epoch == epoch) model_occ++;
          end
        end
        if (id_valid_o && id_ready_i) begin
          pop_count++;
          if (model_occ > 0) model_occ--;
          if (exp_q.size() == 0) fail_now("pop_unexpected");
          else begin
            e = exp_q.pop_front();
            check("pop_pc", id_pc_o, e.pc);
            check("pop_pc4", id_pc_plus4_o, e.pc + 32'd4);
            check("pop_instr", id_instr_o, e.instr);
          end
        end
        if (imem_req_o && imem_gnt_i) begin
          inflight++;
          mem_q.push_back('{addr: imem_addr_o, epoch: epoch,
                            due: cyc + int'($urandom_range(lat_hi, lat_lo))});
          exp_q.push_back('{instr: mem_word(model_addr), pc: model_addr});
          model_addr += 32'd4;
        end
        if (redirect_i) begin
          exp_q.delete();
          model_occ  = 0;
          model_addr = redirect_pc_i & ~32'h3;
          epoch++;
        end
      end
    end
  end

  task automatic tick(input logic g, input logic r);
    mreq_t m;
    @(posedge clk_i);
    #1;
    imem_gnt_i    = g;
    id_ready_i    = r;
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (!rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(m.addr);
      resp_epoch    = m.epoch;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    mem_q.delete();
    #1;
    check("async_rst_req", {31'b0, imem_req_o}, 32'd0);
    check("async_rst_valid", {31'b0, id_valid_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic wait_inflight2(input string name, input bit need_rvalid);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b1);
      if (inflight == 2 && !need_rvalid && !imem_rvalid_i) begin ok = 1; break; end
      if (need_rvalid && imem_rvalid_i && mem_q.size() >= 1) begin ok = 1; break; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic expect_first_pc(input string name, input logic [31:0] pc);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1);
      #1;
      if (id_valid_o) begin
        check(name, id_pc_o, pc);
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now({name, "_timeout"});
  endtask

  initial begin
    int unsigned base;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Streaming at one instruction per cycle
    lat_lo = 1; lat_hi = 1;
    repeat (10) tick(1'b1, 1'b1);
    base = pop_count;
    repeat (20) tick(1'b1, 1'b1);
    check("stream_rate", pop_count - base, 32'd20);

    // Backpressure fills the queue and throttles requests
    repeat (10) tick(1'b1, 1'b0);
    #1;
    check("bp_req", {31'b0, imem_req_o}, 32'd0);
    check("bp_valid", {31'b0, id_valid_o}, 32'd1);
    repeat (10) tick(1'b1, 1'b1);

    // Redirect with two requests in flight
    lat_lo = 3; lat_hi = 3;
    wait_inflight2("wait_outst2", 1'b0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    expect_first_pc("redir_first_pc", 32'h100);

    // Redirect in the same cycle a response lands
    lat_lo = 2; lat_hi = 2;
    repeat (5) tick(1'b1, 1'b1);
    wait_inflight2("wait_rvalid", 1'b1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    check("redir_cycle_valid", {31'b0, id_valid_o}, 32'd0);
    check("redir_cycle_req", {31'b0, imem_req_o}, 32'd0);
    expect_first_pc("redir_rv_first_pc", 32'h100);

    // Grant stall after a misaligned redirect target
    tick(1'b0, 1'b1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    repeat (5) tick(1'b0, 1'b1);
    #1;
    check("stall_addr", imem_addr_o, 32'h100);
    check("stall_req", {31'b0, imem_req_o}, 32'd1);
    repeat (10) tick(1'b1, 1'b1);

    // Reset mid-stream with two outstanding
    lat_lo = 3; lat_hi = 3;
    wait_inflight2("wait_outst2_rst", 1'b0);
    pulse_reset();
    #1;
    check("post_rst_addr", imem_addr_o, RESET_PC);
    repeat (10) tick(1'b1, 1'b1);

    // Random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = $urandom;
      end else if ($urandom_range(0, 699) == 0) begin
        pulse_reset();
      end
    end
    repeat (20) tick(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
